aes_dec_ctrl: RTL and testbench
===============================

# aes_dec_ctrl

Iterative AES-128 decryption controller. It accepts one 128-bit ciphertext block and applies the initial AddRoundKey with round key 10. It then reuses a single `inv_round` datapath ten times: nine full rounds, then one final round with `last=1` that bypasses InvMixColumns. Round keys come in over a synchronous read port from the expanded-key store. The block sits between the host block interface and the key-schedule RAM, and owns all round sequencing.

## Interface
Parameters:
- NR, 10, number of rounds; the round counter width is derived as $clog2(NR+1).
- KEY_AW, 4, key-store address width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  controller can accept a block; high only in IDLE.
- in_data  in  128  ciphertext, byte 0 in bits [127:120].
- key_addr  out  KEY_AW  round-key index requested.
- key_rd  out  1  key read strobe.
- key_data  in  128  round key; valid exactly one cycle after key_rd.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts the plaintext.
- out_data  out  128  plaintext; stable while out_valid is high.
- busy  out  1  high in any state other than IDLE.

## Operation
State machine states: IDLE, ARK, ROUND, DONE.

- **IDLE**
  - in_ready=1.
  - On in_valid: latch in_data into the state register, drive key_addr=NR with key_rd=1, and go to ARK.
- **ARK**
  - state <= state ^ key_data (this is rk[NR]).
  - rnd <= NR-1; issue key_addr=NR-1 with key_rd=1.
  - Go to ROUND.
- **ROUND**
  - state <= inv_round(state, key_data, last=(rnd==0)).
  - If rnd != 0: rnd <= rnd-1 and issue key_addr=rnd-1 with key_rd=1.
  - If rnd == 0: go to DONE.
- **DONE**
  - out_valid=1 and out_data=state.
  - When out_ready is sampled high, go to IDLE.
  - Holds the result indefinitely under backpressure.

Rules:
- key_rd is high for exactly one cycle per key index, in the order NR, NR-1, …, 0.
- key_rd is never asserted in IDLE or DONE.
- There is no round-counter wrap-around: rnd is only decremented when it is nonzero.
- A new block is accepted only from IDLE. A block offered in DONE waits until the cycle after the out handshake.
- The inv_round datapath is purely combinational and is registered only through the state register.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, key_rd=0, key_addr=0, busy=0, state register=0.
- Accept cycle is T0. The key_rd pulses are at T0 through T10.
- The final round (last=1) executes at T11.
- out_valid rises at T12. Fixed latency is 12 cycles from accept to out_valid.
- Throughput is one block per 13 cycles when out_ready is held high.
- Reset asserted in any state returns to IDLE on the next edge:
  - the in-flight block is discarded;
  - out_valid drops with no partial output;
  - no key_rd is issued on the cycle reset is sampled.
- in_valid and out_ready asserted together in DONE: only the output handshake completes. in_ready stays 0 that cycle.

## Structure
- Shared package `aes_pkg`:
  - constants: NR=10, block width 128, key-store address width;
  - FSM state enum {IDLE, ARK, ROUND, DONE};
  - a function for the block/byte ordering convention.
- One natural sub-module: the existing `inv_round` instance, driven by the state register, key_data and the `last` flag.
- The rest (FSM, round counter, state register, output register) is flat RTL in `aes_dec_ctrl`.

## Test plan
1. **FIPS-197 C.1 decryption.** Use key 000102030405060708090a0b0c0d0e0f, expanded into the key-store model, with rk10=13111d7fe3944a17f307a78b4d2b30c5. Input ct=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, with out_valid exactly 12 cycles after accept.
2. **Key sequencing.** Monitor key_rd/key_addr for one block -> addresses 10,9,…,0 on consecutive cycles T0–T10, exactly 11 strobes, and last=1 only at T11.
3. **Backpressure.** Hold out_ready=0 for 20 cycles after out_valid -> out_data constant, in_ready=0, no key_rd; release -> IDLE the next cycle.
4. **Back-to-back blocks.** Two FIPS vectors, in_valid always high, out_ready=1 -> both plaintexts correct, second accepted 13 cycles after the first.
5. **Reset mid-operation.** Assert rst at T5 for one cycle -> next cycle in_ready=1, busy=0, out_valid=0. A following block decrypts correctly with the full 12-cycle latency.
6. **Reset values.** Hold rst for 3 cycles with random inputs -> every output matches its reset value and no key_rd is issued.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decryption constants, FSM encoding and block byte-ordering helpers.
// Byte 0 of a block lives in bits [127:120]; column c holds bytes 4c..4c+3 (rows 0..3).
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_BLK_W  = 128;
  localparam int AES_KEY_AW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARK   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  function automatic logic [7:0] blk_byte(input logic [AES_BLK_W-1:0] blk, input int unsigned idx);
    return blk[AES_BLK_W-1-8*idx -: 8];
  endfunction

endpackage

// File: rtl/aes_dec_ctrl_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Purely combinational; the caller registers the result.
module inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] round_key,
  input  logic                 last,
  output logic [AES_BLK_W-1:0] state_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = gf_mul(a, a);
    r = t;
    for (int i = 0; i < 6; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8];
    end
    return gf_inv(y ^ 8'h05);
  endfunction

  logic [7:0] add_b [16];
  logic [7:0] mix_b [4];

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      // row r of column c comes from column (c - r) mod 4
      add_b[i] = inv_sbox(blk_byte(state_in, 4*(((i/4) - (i%4) + 4) % 4) + (i%4)))
                 ^ blk_byte(round_key, i);
    end
    for (int c = 0; c < 4; c++) begin
      mix_b[0] = gf_mul(8'h0e, add_b[4*c]) ^ gf_mul(8'h0b, add_b[4*c+1])
               ^ gf_mul(8'h0d, add_b[4*c+2]) ^ gf_mul(8'h09, add_b[4*c+3]);
      mix_b[1] = gf_mul(8'h09, add_b[4*c]) ^ gf_mul(8'h0e, add_b[4*c+1])
               ^ gf_mul(8'h0b, add_b[4*c+2]) ^ gf_mul(8'h0d, add_b[4*c+3]);
      mix_b[2] = gf_mul(8'h0d, add_b[4*c]) ^ gf_mul(8'h09, add_b[4*c+1])
               ^ gf_mul(8'h0e, add_b[4*c+2]) ^ gf_mul(8'h0b, add_b[4*c+3]);
      mix_b[3] = gf_mul(8'h0b, add_b[4*c]) ^ gf_mul(8'h0d, add_b[4*c+1])
               ^ gf_mul(8'h09, add_b[4*c+2]) ^ gf_mul(8'h0e, add_b[4*c+3]);
      for (int r = 0; r < 4; r++) begin
        if (last) begin
          state_out[AES_BLK_W-1-8*(4*c+r) -: 8] = add_b[4*c+r];
        end else begin
          state_out[AES_BLK_W-1-8*(4*c+r) -: 8] = mix_b[r];
        end
      end
    end
  end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decryption controller: initial AddRoundKey with rk[NR], then NR
// inverse rounds through one shared inv_round, fetching round keys NR..0 from the key store.
module aes_dec_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KEY_AW = AES_KEY_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic [KEY_AW-1:0]    key_addr,
  output logic                 key_rd,
  input  logic [AES_BLK_W-1:0] key_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  localparam int RW = $clog2(NR + 1);

  fsm_e                 fsm;
  logic [RW-1:0]        rnd;
  logic [AES_BLK_W-1:0] blk;
  logic [AES_BLK_W-1:0] round_out;
  logic                 last;

  assign last = (fsm == ROUND) && (rnd == '0);

  inv_round u_inv_round (
    .state_in  (blk),
    .round_key (key_data),
    .last      (last),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      rnd <= '0;
      blk <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            blk <= in_data;
            fsm <= ARK;
          end
        end
        ARK: begin
          blk <= blk ^ key_data;
          rnd <= RW'(NR - 1);
          fsm <= ROUND;
        end
        ROUND: begin
          blk <= round_out;
          if (rnd != '0) begin
            rnd <= rnd - RW'(1);
          end else begin
            fsm <= DONE;
          end
        end
        DONE: begin
          if (out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Key requests lead their use by one cycle; suppressed while reset is sampled.
  always_comb begin
    key_rd   = 1'b0;
    key_addr = '0;
    if (rst) begin
      key_rd   = 1'b0;
      key_addr = '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            key_rd   = 1'b1;
            key_addr = KEY_AW'(NR);
          end else begin
            key_rd   = 1'b0;
          end
        end
        ARK: begin
          key_rd   = 1'b1;
          key_addr = KEY_AW'(NR - 1);
        end
        ROUND: begin
          if (rnd != '0) begin
            key_rd   = 1'b1;
            key_addr = KEY_AW'(rnd - RW'(1));
          end else begin
            key_rd   = 1'b0;
          end
        end
        default: key_rd = 1'b0;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_data  = blk;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Self-checking bench for aes_dec_ctrl: FIPS-197 vectors from a key-store model,
// key sequencing, backpressure, back-to-back blocks and reset behaviour.
module tb_aes_dec_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   key_addr;
  logic         key_rd;
  logic [127:0] key_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int key_sel = 0;
  int active_sel = 0;
  int kr_total = 0;
  int last_total = 0;
  int last_cyc = -1;
  int kr_addr [256];
  int kr_cyc [256];
  logic [127:0] ks [2][11];

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           sel;
    int           hold;
  } vec_t;
  vec_t vecs [5];

  aes_dec_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_addr  (key_addr),
    .key_rd    (key_rd),
    .key_data  (key_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ks_rd(input int s, input int a);
    if (s < 0 || s > 1 || a < 0 || a > 10) return '0;
    return ks[s][a];
  endfunction

  // Key store: synchronous read; key set latched per accepted block.
  always @(posedge clk) begin
    if (in_ready && in_valid && !rst) active_sel <= key_sel;
    if (key_rd) key_data <= ks_rd((in_ready && in_valid) ? key_sel : active_sel, int'(key_addr));
  end

  // Cycle counter plus key-strobe and last-round log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (key_rd) begin
      if (kr_total < 256) begin
        kr_addr[kr_total] <= int'(key_addr);
        kr_cyc[kr_total]  <= cyc;
      end
      kr_total <= kr_total + 1;
    end
    if (dut.last) begin
      last_total <= last_total + 1;
      last_cyc   <= cyc;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run_block(input vec_t v);
    int acc, n, kb, lb, bad;
    @(negedge clk);
    in_data = v.ct; in_valid = 1'b1; key_sel = v.sel; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_wait", 128'(n < 50), 128'd1);
    acc = cyc; kb = kr_total; lb = last_total;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("latency", 128'(cyc - acc), 128'd12);
    check("plaintext", out_data, v.pt);
    check("key_rd_count", 128'(kr_total - kb), 128'd11);
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      if (kb + i < 256) begin
        if (kr_addr[kb+i] != 10 - i || kr_cyc[kb+i] != acc + i) bad++;
      end
    end
    check("key_seq", 128'(bad), 128'd0);
    check("last_count", 128'(last_total - lb), 128'd1);
    check("last_cycle", 128'(last_cyc - acc), 128'd11);
    bad = 0; kb = kr_total;
    for (int h = 0; h < v.hold; h++) begin
      if (out_data !== v.pt || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(negedge clk);
    end
    check("hold_stable", 128'(bad), 128'd0);
    check("hold_no_key_rd", 128'(kr_total - kb), 128'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {in_ready, busy, out_valid}, 128'b100);
  endtask

  initial begin
    int acc1, acc2, nout, bad, acc, kb;
    int ocyc [2];
    logic [127:0] outs [2];

    ks[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
    ks[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    ks[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    ks[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    ks[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    ks[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    ks[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    ks[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    ks[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    ks[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    ks[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    ks[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ks[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ks[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ks[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ks[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ks[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ks[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ks[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ks[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ks[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
    ks[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0, 0};
    vecs[1] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 1, 2};
    vecs[2] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0, 20};
    vecs[3] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 1, 0};
    vecs[4] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0, 1};

    // Reset held three cycles under random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("rst_key_rd", {127'd0, key_rd}, 128'd0);
      if (i > 0) begin
        check("rst_outs", {in_ready, out_valid, busy, key_addr}, {121'd0, 7'b1000000});
        check("rst_out_data", out_data, 128'd0);
      end
    end
    @(negedge clk);
    check("rst_no_strobes", 128'(kr_total), 128'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    for (int v = 0; v < 5; v++) run_block(vecs[v]);

    // Back-to-back: in_valid held high, out_ready held high.
    @(negedge clk);
    key_sel = 0; in_data = vecs[0].ct; in_valid = 1'b1; out_ready = 1'b1;
    acc1 = -1; acc2 = -1; nout = 0; bad = 0;
    for (int i = 0; i < 40 && nout < 2; i++) begin
      if (in_ready && in_valid) begin
        if (acc1 < 0) acc1 = cyc;
        else if (acc2 < 0) acc2 = cyc;
      end
      if (out_valid) begin
        if (in_ready !== 1'b0) bad++;
        outs[nout] = out_data;
        ocyc[nout] = cyc;
        nout++;
      end
      @(negedge clk);
      if (acc2 >= 0) in_valid = 1'b0;
      else if (acc1 >= 0) begin
        key_sel = 1; in_data = vecs[1].ct;
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b_count", 128'(nout), 128'd2);
    check("b2b_spacing", 128'(acc2 - acc1), 128'd13);
    check("b2b_pt0", outs[0], vecs[0].pt);
    check("b2b_pt1", outs[1], vecs[1].pt);
    check("b2b_lat1", 128'(ocyc[1] - acc2), 128'd12);
    check("b2b_done_ready", 128'(bad), 128'd0);

    // Reset at T5 of an in-flight block.
    @(negedge clk);
    check("mid_ready", {127'd0, in_ready}, 128'd1);
    key_sel = 0; in_data = vecs[0].ct; in_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < acc + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_key_rd", {127'd0, key_rd}, 128'd0);
    kb = kr_total;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_outs", {in_ready, busy, out_valid}, 128'b100);
    check("mid_rst_no_strobe", 128'(kr_total - kb), 128'd0);
    run_block(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
